// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared MIPS core types plus the fetch/request sequencer states
package cpu_types_pkg;

    localparam int WORD_W  = 32;
    localparam int OP_W    = 6;
    localparam int FUNCT_W = 6;

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [OP_W-1:0]    opcode_t;
    typedef logic [FUNCT_W-1:0] funct_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        HALT  = 2'd3
    } reqstate_t;

    function automatic opcode_t instr_opcode(input word_t w);
        return w[WORD_W-1 -: OP_W];
    endfunction

    function automatic funct_t instr_funct(input word_t w);
        return w[FUNCT_W-1:0];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              clr,
    output logic [PERF_W-1:0] count
);

    logic [PERF_W-1:0] count_q;
    logic [PERF_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_request_unit.sv
// rtl/fetch_request_unit.sv - multi-cycle fetch/memory-request sequencer; FETCH_REQUEST_PERF_EN adds perf counters
module fetch_request_unit
    import cpu_types_pkg::*;
#(
    parameter int          PERF_W        = 32,
    parameter int unsigned IMEM_WAIT_MAX = 0
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic [31:0] imemload,
    input  logic [31:0] dmemload,
    input  logic [31:0] pc,
    input  logic        cu_dREN,
    input  logic        cu_dWEN,
    input  logic        cu_halt,
    input  logic [31:0] daddr_in,
    input  logic [31:0] dstore_in,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic [31:0] instr,
    output logic [31:0] dload,
    output logic        pc_en,
    output logic        reg_wen,
    output logic        halt,
    output logic        fetch_timeout
`ifdef FETCH_REQUEST_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_instr,
    output logic [PERF_W-1:0] perf_istall,
    output logic [PERF_W-1:0] perf_dstall
`endif
);

    reqstate_t         state_q,   state_d;
    word_t             instr_q,   instr_d;
    word_t             dload_q,   dload_d;
    word_t             daddr_q,   daddr_d;
    word_t             dstore_q,  dstore_d;
    logic              store_q,   store_d;
    logic [PERF_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;
    logic              retire;

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        dload_d  = dload_q;
        daddr_d  = daddr_q;
        dstore_d = dstore_q;
        store_d  = store_q;
        retire   = 1'b0;
        case (state_q)
            FETCH: begin
                if (ihit) begin
                    instr_d = imemload;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cu_halt) begin
                    state_d = HALT;
                end else if (cu_dREN || cu_dWEN) begin
                    // Store wins when the decode asserts both directions.
                    daddr_d  = daddr_in;
                    dstore_d = dstore_in;
                    store_d  = cu_dWEN;
                    state_d  = MEM;
                end else begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            MEM: begin
                if (dhit) begin
                    if (!store_q) begin
                        dload_d = dmemload;
                    end
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    // Wait counter shares the perf width and only runs while fetch is stalled.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        if (state_q == FETCH) begin
            if (ihit) begin
                wait_cnt_d = '0;
            end else if (wait_cnt_q != '1) begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end
        if ((IMEM_WAIT_MAX != 0) && (wait_cnt_d == PERF_W'(IMEM_WAIT_MAX))) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= FETCH;
            instr_q    <= '0;
            dload_q    <= '0;
            daddr_q    <= '0;
            dstore_q   <= '0;
            store_q    <= 1'b0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            dload_q    <= dload_d;
            daddr_q    <= daddr_d;
            dstore_q   <= dstore_d;
            store_q    <= store_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign imemREN       = (state_q == FETCH);
    assign imemaddr      = pc;
    assign dmemREN       = (state_q == MEM) && !store_q;
    assign dmemWEN       = (state_q == MEM) &&  store_q;
    assign dmemaddr      = daddr_q;
    assign dmemstore     = dstore_q;
    assign instr         = instr_q;
    assign dload         = dload_q;
    assign pc_en         = retire;
    assign reg_wen       = retire;
    assign halt          = (state_q == HALT);
    assign fetch_timeout = timeout_q;

`ifdef FETCH_REQUEST_PERF_EN
    // Nothing increments in HALT, so the counters freeze there on their own.
    sat_counter #(.PERF_W(PERF_W)) u_perf_instr (
        .clk   (CLK),
        .rst_n (nRST),
        .inc   (retire),
        .clr   (1'b0),
        .count (perf_instr)
    );

    sat_counter #(.PERF_W(PERF_W)) u_perf_istall (
        .clk   (CLK),
        .rst_n (nRST),
        .inc   ((state_q == FETCH) && !ihit),
        .clr   (1'b0),
        .count (perf_istall)
    );

    sat_counter #(.PERF_W(PERF_W)) u_perf_dstall (
        .clk   (CLK),
        .rst_n (nRST),
        .inc   ((state_q == MEM) && !dhit),
        .clr   (1'b0),
        .count (perf_dstall)
    );
`endif

endmodule

// File: tb/tb_fetch_request_unit.sv
// tb/tb_fetch_request_unit.sv - self-checking bench for fetch_request_unit
module tb_fetch_request_unit;

    localparam int PERF_W = 32;

    logic        CLK, nRST, ihit, dhit;
    logic [31:0] imemload, dmemload, pc, daddr_in, dstore_in;
    logic        cu_dREN, cu_dWEN, cu_halt;
    logic        imemREN, dmemREN, dmemWEN, pc_en, reg_wen, halt, fetch_timeout;
    logic [31:0] imemaddr, dmemaddr, dmemstore, instr, dload;
    logic [PERF_W-1:0] perf_instr, perf_istall, perf_dstall;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_dload;
    int exp_retired, exp_istall, exp_dstall;

    fetch_request_unit #(.PERF_W(PERF_W), .IMEM_WAIT_MAX(4)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .imemload(imemload), .dmemload(dmemload), .pc(pc),
        .cu_dREN(cu_dREN), .cu_dWEN(cu_dWEN), .cu_halt(cu_halt),
        .daddr_in(daddr_in), .dstore_in(dstore_in),
        .imemREN(imemREN), .imemaddr(imemaddr), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .instr(instr), .dload(dload),
        .pc_en(pc_en), .reg_wen(reg_wen), .halt(halt), .fetch_timeout(fetch_timeout)
`ifdef FETCH_REQUEST_PERF_EN
        , .perf_instr(perf_instr), .perf_istall(perf_istall), .perf_dstall(perf_dstall)
`endif
    );

`ifndef FETCH_REQUEST_PERF_EN
    assign perf_instr  = '0;
    assign perf_istall = '0;
    assign perf_dstall = '0;
`endif

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ihit = 0; dhit = 0; imemload = 0; dmemload = 0;
        cu_dREN = 0; cu_dWEN = 0; cu_halt = 0; daddr_in = 0; dstore_in = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        nRST = 1'b0;
        tick();
        tick();
        nRST = 1'b1;
        pc = 32'h0;
        exp_dload = 0; exp_retired = 0; exp_istall = 0; exp_dstall = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        nRST = 1'b1;
        pc = 32'h40;
        tick();
        nRST = 1'b0;
        #1;
        checks++; if ({imemREN, dmemREN, dmemWEN, pc_en, reg_wen, halt, fetch_timeout} !== 7'b1000000) begin
            errors++; $display("FAIL reset_ctl: got %b want %b", {imemREN, dmemREN, dmemWEN, pc_en, reg_wen, halt, fetch_timeout}, 7'b1000000);
        end
        checks++; if ({instr, dload, dmemaddr, dmemstore} !== 128'h0) begin
            errors++; $display("FAIL reset_regs: got %h %h %h %h want all zero", instr, dload, dmemaddr, dmemstore);
        end
        checks++; if (imemaddr !== 32'h40) begin
            errors++; $display("FAIL reset_imemaddr: got %h want %h", imemaddr, 32'h40);
        end
        nRST = 1'b1;
    endtask

    task automatic test_alu();
        apply_reset();
        @(negedge CLK);
        checks++; if ({imemREN, pc_en} !== 2'b10) begin
            errors++; $display("FAIL alu_fetch_wait: got %b want %b", {imemREN, pc_en}, 2'b10);
        end
        tick();
        ihit = 1; imemload = 32'h00221820;
        tick();
        ihit = 0; imemload = 32'hFFFFFFFF;
        @(negedge CLK);
        checks++; if (instr !== 32'h00221820) begin
            errors++; $display("FAIL alu_instr: got %h want %h", instr, 32'h00221820);
        end
        checks++; if ({imemREN, pc_en, reg_wen} !== 3'b011) begin
            errors++; $display("FAIL alu_exec_strobes: got %b want %b", {imemREN, pc_en, reg_wen}, 3'b011);
        end
        tick();
        pc = pc + 4;
        @(negedge CLK);
        checks++; if ({imemREN, pc_en, reg_wen} !== 3'b100) begin
            errors++; $display("FAIL alu_back_to_fetch: got %b want %b", {imemREN, pc_en, reg_wen}, 3'b100);
        end
    endtask

    task automatic test_load();
        int ren_cycles = 0;
        ihit = 1; imemload = 32'h8C220004;
        tick();
        ihit = 0; cu_dREN = 1; daddr_in = 32'h100; dstore_in = $urandom;
        @(negedge CLK);
        checks++; if ({pc_en, reg_wen} !== 2'b00) begin
            errors++; $display("FAIL lw_exec_strobes: got %b want %b", {pc_en, reg_wen}, 2'b00);
        end
        tick();
        for (int j = 0; j <= 3; j++) begin
            cu_dREN = 0; daddr_in = $urandom;
            dhit = (j == 3);
            dmemload = (j == 3) ? 32'hDEADBEEF : $urandom;
            @(negedge CLK);
            if (dmemREN === 1'b1) ren_cycles++;
            checks++; if ({dmemWEN, pc_en} !== {1'b0, j == 3} || dmemaddr !== 32'h100) begin
                errors++; $display("FAIL lw_mem_cycle%0d: got wen=%b pc_en=%b addr=%h want 0 %b 00000100", j, dmemWEN, pc_en, dmemaddr, j == 3);
            end
            tick();
        end
        dhit = 0; pc = pc + 4;
        @(negedge CLK);
        checks++; if (ren_cycles != 4 || dmemREN !== 1'b0) begin
            errors++; $display("FAIL lw_ren_cycles: got %0d (now %b) want 4 (now 0)", ren_cycles, dmemREN);
        end
        checks++; if (dload !== 32'hDEADBEEF) begin
            errors++; $display("FAIL lw_dload: got %h want %h", dload, 32'hDEADBEEF);
        end
    endtask

    task automatic test_store();
        ihit = 1; imemload = 32'hAC220008;
        tick();
        ihit = 0; cu_dREN = 1; cu_dWEN = 1; daddr_in = 32'h200; dstore_in = 32'h12345678;
        tick();
        for (int j = 0; j <= 2; j++) begin
            cu_dREN = 0; cu_dWEN = 0;
            daddr_in = ~daddr_in; dstore_in = $urandom;
            dhit = (j == 2); dmemload = $urandom;
            @(negedge CLK);
            checks++; if ({dmemREN, dmemWEN, pc_en} !== {2'b01, j == 2}) begin
                errors++; $display("FAIL sw_ctl_cycle%0d: got %b want %b", j, {dmemREN, dmemWEN, pc_en}, {2'b01, j == 2});
            end
            checks++; if ({dmemaddr, dmemstore} !== {32'h200, 32'h12345678}) begin
                errors++; $display("FAIL sw_latched_cycle%0d: got %h %h want 00000200 12345678", j, dmemaddr, dmemstore);
            end
            tick();
        end
        dhit = 0; pc = pc + 4;
        @(negedge CLK);
        checks++; if (dload !== 32'hDEADBEEF) begin
            errors++; $display("FAIL sw_dload_unchanged: got %h want %h", dload, 32'hDEADBEEF);
        end
    endtask

    task automatic test_random();
        logic [31:0] word, addr, sdata, ldata;
        int kind, wi, wd;
        apply_reset();
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2); wi = $urandom_range(0, 3); wd = $urandom_range(0, 3);
            word = $urandom; addr = $urandom; sdata = $urandom; ldata = $urandom;
            for (int c = 0; c <= wi; c++) begin
                ihit = (c == wi); imemload = (c == wi) ? word : $urandom;
                dhit = 1'($urandom_range(0, 1)); dmemload = $urandom;
                cu_dREN = 1'($urandom_range(0, 1)); cu_dWEN = 1'($urandom_range(0, 1)); cu_halt = 1'($urandom_range(0, 1));
                @(negedge CLK);
                checks++; if ({imemREN, dmemREN, dmemWEN, pc_en, reg_wen} !== 5'b10000 || imemaddr !== pc) begin
                    errors++; $display("FAIL rnd_fetch n=%0d: got %b addr=%h want 10000 addr=%h", n, {imemREN, dmemREN, dmemWEN, pc_en, reg_wen}, imemaddr, pc);
                end
                if (c == 0) begin
                    checks++; if (dload !== exp_dload || fetch_timeout !== 1'b0) begin
                        errors++; $display("FAIL rnd_dload n=%0d: got %h to=%b want %h to=0", n, dload, fetch_timeout, exp_dload);
                    end
                end
                tick();
            end
            ihit = 1'($urandom_range(0, 1)); imemload = $urandom; dhit = 1'($urandom_range(0, 1));
            cu_halt = 0; cu_dWEN = (kind == 2);
            cu_dREN = (kind == 1) ? 1'b1 : ((kind == 2) ? 1'($urandom_range(0, 1)) : 1'b0);
            daddr_in = addr; dstore_in = sdata;
            @(negedge CLK);
            checks++; if (instr !== word || {imemREN, dmemREN, dmemWEN, pc_en, reg_wen} !== {3'b000, kind == 0, kind == 0}) begin
                errors++; $display("FAIL rnd_exec n=%0d: got %h %b want %h %b", n, instr, {imemREN, dmemREN, dmemWEN, pc_en, reg_wen}, word, {3'b000, kind == 0, kind == 0});
            end
            tick();
            if (kind != 0) begin
                for (int j = 0; j <= wd; j++) begin
                    dhit = (j == wd); dmemload = (j == wd) ? ldata : $urandom;
                    ihit = 1'($urandom_range(0, 1)); daddr_in = $urandom; dstore_in = $urandom;
                    cu_dREN = 1'($urandom_range(0, 1)); cu_dWEN = 1'($urandom_range(0, 1)); cu_halt = 1'($urandom_range(0, 1));
                    @(negedge CLK);
                    checks++; if ({imemREN, dmemREN, dmemWEN, pc_en, reg_wen} !== {1'b0, kind == 1, kind == 2, j == wd, j == wd} || {dmemaddr, dmemstore} !== {addr, sdata}) begin
                        errors++; $display("FAIL rnd_mem n=%0d j=%0d: got %b %h %h want %b %h %h", n, j, {imemREN, dmemREN, dmemWEN, pc_en, reg_wen}, dmemaddr, dmemstore, {1'b0, kind == 1, kind == 2, j == wd, j == wd}, addr, sdata);
                    end
                    tick();
                end
                if (kind == 1) exp_dload = ldata;
                exp_dstall += wd;
            end
            pc = pc + 4;
            exp_retired++;
            exp_istall += wi;
        end
        idle_inputs();
        @(negedge CLK);
        checks++; if (dload !== exp_dload) begin
            errors++; $display("FAIL rnd_final_dload: got %h want %h", dload, exp_dload);
        end
`ifdef FETCH_REQUEST_PERF_EN
        checks++; if ({perf_instr, perf_istall, perf_dstall} !== {PERF_W'(exp_retired), PERF_W'(exp_istall), PERF_W'(exp_dstall)}) begin
            errors++; $display("FAIL rnd_perf: got %0d %0d %0d want %0d %0d %0d", perf_instr, perf_istall, perf_dstall, exp_retired, exp_istall, exp_dstall);
        end
`endif
    endtask

    task automatic test_reset_mid_mem();
        apply_reset();
        ihit = 1; imemload = 32'h8C230010;
        tick();
        ihit = 0; cu_dREN = 1; daddr_in = 32'h300;
        tick();
        cu_dREN = 0; dhit = 0; dmemload = 32'hCAFEF00D;
        @(negedge CLK);
        checks++; if (dmemREN !== 1'b1) begin
            errors++; $display("FAIL midrst_pre: got dmemREN=%b want 1", dmemREN);
        end
        #2;
        nRST = 1'b0;
        dhit = 1;
        #1;
        checks++; if ({dmemREN, dmemWEN, pc_en, reg_wen} !== 4'b0000) begin
            errors++; $display("FAIL midrst_async_drop: got %b want %b", {dmemREN, dmemWEN, pc_en, reg_wen}, 4'b0000);
        end
        tick();
        nRST = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            checks++; if ({imemREN, dmemREN, pc_en, reg_wen, halt} !== 5'b10000 || dload !== 32'h0) begin
                errors++; $display("FAIL midrst_after%0d: got %b dload=%h want 10000 dload=0", c, {imemREN, dmemREN, pc_en, reg_wen, halt}, dload);
            end
            tick();
        end
        dhit = 0;
    endtask

    task automatic test_timeout();
        apply_reset();
        for (int k = 1; k <= 6; k++) begin
            ihit = 0; pc = $urandom;
            tick();
            @(negedge CLK);
            checks++; if (fetch_timeout !== (k >= 4) || imemREN !== 1'b1 || imemaddr !== pc) begin
                errors++; $display("FAIL timeout_k%0d: got to=%b ren=%b addr=%h want to=%b ren=1 addr=%h", k, fetch_timeout, imemREN, imemaddr, k >= 4, pc);
            end
`ifdef FETCH_REQUEST_PERF_EN
            if (k == 4) begin
                checks++; if (perf_istall !== PERF_W'(4)) begin
                    errors++; $display("FAIL timeout_istall: got %0d want 4", perf_istall);
                end
            end
`endif
        end
        tick();
        ihit = 1; imemload = 32'h00000020;
        tick();
        ihit = 0;
        @(negedge CLK);
        checks++; if ({pc_en, fetch_timeout} !== 2'b11) begin
            errors++; $display("FAIL timeout_sticky: got %b want %b", {pc_en, fetch_timeout}, 2'b11);
        end
        tick();
    endtask

    task automatic test_halt();
        apply_reset();
        tick();
        ihit = 1; imemload = 32'h00432020;
        tick();
        ihit = 0;
        tick();
        pc = pc + 4;
        ihit = 1; imemload = 32'h0000000C;
        tick();
        ihit = 1; cu_halt = 1; cu_dREN = 1;
        @(negedge CLK);
        checks++; if ({pc_en, reg_wen, halt} !== 3'b000) begin
            errors++; $display("FAIL halt_exec: got %b want %b", {pc_en, reg_wen, halt}, 3'b000);
        end
        tick();
        for (int c = 0; c < 20; c++) begin
            ihit = 1; dhit = 1; cu_halt = 0;
            cu_dREN = 1'($urandom_range(0, 1)); cu_dWEN = 1'($urandom_range(0, 1));
            @(negedge CLK);
            checks++; if ({halt, imemREN, dmemREN, dmemWEN, pc_en, reg_wen} !== 6'b100000) begin
                errors++; $display("FAIL halt_cycle%0d: got %b want %b", c, {halt, imemREN, dmemREN, dmemWEN, pc_en, reg_wen}, 6'b100000);
            end
            tick();
        end
`ifdef FETCH_REQUEST_PERF_EN
        checks++; if ({perf_instr, perf_istall, perf_dstall} !== {PERF_W'(1), PERF_W'(1), PERF_W'(0)}) begin
            errors++; $display("FAIL halt_perf_frozen: got %0d %0d %0d want 1 1 0", perf_instr, perf_istall, perf_dstall);
        end
`endif
        idle_inputs();
    endtask

    initial begin
        nRST = 1'b1;
        pc = 32'h0;
        idle_inputs();
        exp_dload = 0; exp_retired = 0; exp_istall = 0; exp_dstall = 0;
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_random();
        test_reset_mid_mem();
        test_timeout();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_request_unit.md
Name: fetch_request_unit

Overview:
- Multi-cycle fetch and memory-request sequencer for the MIPS core.
- Fetches the instruction at the current PC and latches it into an instruction register that feeds the control unit's opcode/funct.
- Consumes the control unit's dREN/dWEN/halt decisions and drives the memory-side request lines.
- Generates the PC enable and the register-write qualifier, so each instruction retires exactly once.

Parameters:
- PERF_W, 32, width of the optional performance counters; the counters saturate at all-ones.
- IMEM_WAIT_MAX, 0, number of FETCH cycles without ihit before fetch_timeout asserts; 0 disables the timeout.

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction memory hit; imemload is valid in this cycle
- dhit  in  1  data memory hit; dmemload is valid, or the store has completed
- imemload  in  32  instruction word from memory
- pc  in  32  current PC (word_t)
- cu_dREN  in  1  control-unit load request for instr
- cu_dWEN  in  1  control-unit store request for instr
- cu_halt  in  1  control-unit halt decode
- daddr_in  in  32  ALU result used as the data address
- dstore_in  in  32  rt value to store
- imemREN  out  1  instruction read request
- imemaddr  out  32  instruction address
- dmemREN  out  1  data read request
- dmemWEN  out  1  data write request
- dmemaddr  out  32  latched data address
- dmemstore  out  32  latched store data
- instr  out  32  instruction register; opcode = instr[31:26], funct = instr[5:0]
- dload  out  32  latched load data
- pc_en  out  1  one-cycle PC update strobe
- reg_wen  out  1  one-cycle register-file write qualifier, ANDed with RegWrite
- halt  out  1  sticky halted flag
- fetch_timeout  out  1  sticky; set when IMEM_WAIT_MAX is nonzero and is reached

Behaviour:
- Clock and reset: one clock, CLK. Reset is nRST, asynchronous and active-low.
- Reset values:
  - State goes to FETCH.
  - instr, dload, dmemaddr and dmemstore reset to 0.
  - dmemREN, dmemWEN, pc_en, reg_wen, halt and fetch_timeout reset to 0.
  - imemREN is 1 after reset, because it is decoded from FETCH.
- State enum reqstate_t: FETCH, EXEC, MEM, HALT. State is registered; outputs are decoded from state, as Moore outputs except where noted.
- FETCH:
  - imemREN=1 and imemaddr=pc.
  - On ihit: instr<=imemload, then go to EXEC.
  - Without ihit: stay in FETCH and increment the wait counter.
- EXEC (one cycle; control-unit outputs are combinational from instr):
  - If cu_halt: go to HALT. pc_en=0 and reg_wen=0.
  - Else if cu_dREN or cu_dWEN: latch daddr_in and dstore_in, latch the direction bit (dWEN has priority when both are asserted), then go to MEM. pc_en=0.
  - Else: pc_en=1 and reg_wen=1 in this cycle (Mealy), then go to FETCH.
- MEM:
  - Exactly one of dmemREN/dmemWEN is held at 1 until dhit. dmemaddr and dmemstore stay stable for the whole access.
  - On dhit: dload<=dmemload for loads (dload is unchanged for stores). pc_en=1 and reg_wen=1 (Mealy), then go to FETCH.
  - The register file sees dload from the cycle after dhit. The datapath therefore writes on the reg_wen of the load's dhit cycle using the bypass dmemload, and the control unit's MemToReg selects that bypass.
- HALT:
  - Terminal until nRST. All requests are 0; halt=1; pc_en=0.
- Latency: a non-memory instruction takes 2 cycles at minimum (FETCH with ihit, then EXEC). A memory instruction takes 3 cycles at minimum.
- Boundary conditions:
  - ihit outside FETCH is ignored; dhit outside MEM is ignored.
  - ihit and dhit in the same cycle: only the one matching the current state acts.
  - pc changing while in FETCH without ihit: imemaddr follows pc combinationally. pc must not change, because pc_en=0.
  - Reset asserted mid-access drops dmemREN/dmemWEN immediately (asynchronously). The aborted access has no retirement side effects.
  - The wait counter clears on ihit. fetch_timeout sets when the counter equals IMEM_WAIT_MAX, and the FSM keeps waiting.

Optional Feature:
- Macro: FETCH_REQUEST_PERF_EN.
- Defined: adds the output ports perf_instr, perf_istall and perf_dstall, each PERF_W wide. They count respectively retired instructions (pc_en pulses), FETCH cycles without ihit, and MEM cycles without dhit. All three reset to 0 on nRST, saturate at all-ones, and freeze in HALT.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- cpu_types_pkg gains reqstate_t and the constants OP_W=6 and FUNCT_W=6. It already supplies word_t, opcode_t and funct_t.
- The sub-module sat_counter (PERF_W, inc, clr) is instantiated three times, only under the macro.

Test Plan:
- Reset then ihit on cycle 2 with imemload=0x00221820 (ADD), cu_dREN=cu_dWEN=0 -> instr=0x00221820 in EXEC; pc_en=1 and reg_wen=1 for exactly one cycle; back in FETCH.
- LW 0x8C220004 with daddr_in=0x100 and dhit delayed 3 cycles, dmemload=0xDEADBEEF -> dmemREN held for 4 cycles with dmemaddr=0x100; pc_en pulses on the dhit cycle; dload=0xDEADBEEF.
- SW with dstore_in=0x12345678, then daddr_in toggling while waiting -> dmemWEN=1 and dmemaddr/dmemstore stay at their latched values until dhit; dload unchanged.
- cu_halt=1 in EXEC -> halt=1 from the next cycle; no requests; pc_en=0 for 20 further cycles despite ihit=1.
- nRST pulsed mid-MEM -> dmemREN drops in the same cycle; state is FETCH after release; halt=0; no pc_en pulse.
- With IMEM_WAIT_MAX=4 and ihit withheld -> fetch_timeout rises after 4 FETCH cycles. With FETCH_REQUEST_PERF_EN defined -> perf_istall=4 at that point.
